arbiter_rr2: RTL and testbench

Two-requester round-robin arbiter: the grant-driving end of the 2-bit request/grant arbiter interface. Testbench or client logic drives `request`; this block returns a registered, mutually exclusive `grant`. Optional hold-limit preemption bounds how long one owner can starve the other.

---
 rtl/arbiter_rr2_pkg.sv | 25 ++
 rtl/arbiter_rr2_if.sv | 13 +
 rtl/arbiter_rr2_hold_timer.sv | 37 +++
 rtl/arbiter_rr2.sv | 118 +++++++++++
 tb/tb_arbiter_rr2.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbiter_rr2_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_G0,
        ARB_G1
    } arb_state_t;

    localparam int ARB_N = 2;
    localparam logic ARB_RESET_OWNER = 1'b1;

    // Grant vector implied by an arbiter state; one-hot or zero by construction.
    function automatic logic [ARB_N-1:0] grant_of(input arb_state_t s);
        logic [ARB_N-1:0] g;
        g = '0;
        case (s)
            ARB_G0:  g = 2'b01;
            ARB_G1:  g = 2'b10;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/arbiter_rr2_if.sv
// Request/grant bundle between client logic (master) and the arbiter (slave).
interface arbiter_rr2_if;
    import arbiter_pkg::*;

    logic [ARB_N-1:0] request;
    logic [ARB_N-1:0] grant;
    logic             last_owner;
    logic             preempt;

    modport master (output request, input grant, input last_owner, input preempt);
    modport slave  (input request, output grant, output last_owner, output preempt);

endinterface

// File: rtl/arbiter_rr2_hold_timer.sv
// Consecutive-contention counter; expire flags the MAX_HOLD-th contended cycle.
module arbiter_hold_timer #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expire
);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expire = (count_q == CW'(MAX_HOLD - 1));

    // Next count: clear wins, otherwise count up without passing the limit.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !expire) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/arbiter_rr2.sv
// Two-requester round-robin arbiter with registered one-hot grant.
// Optional hold-limit preemption compiled in with `define ARB_HOLD_LIMIT_EN.
module arbiter_rr2
    import arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic         clk,
    input logic         rst,
    arbiter_rr2_if.slave bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("arbiter_rr2: MAX_HOLD out of range 2..255");
    end

    arb_state_t state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       expire;

`ifdef ARB_HOLD_LIMIT_EN
    logic preempt_q, preempt_d;
    logic other_req;
    logic inc, clr;

    // Count only while the non-owner is waiting; any ownership change restarts.
    always_comb begin
        other_req = 1'b0;
        if (state_q == ARB_G0) other_req = bus.request[1];
        if (state_q == ARB_G1) other_req = bus.request[0];
        inc = other_req;
        clr = (state_d != state_q) || !other_req;
    end

    arbiter_hold_timer #(
        .MAX_HOLD(MAX_HOLD)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc),
        .clr    (clr),
        .expire (expire)
    );

    assign bus.preempt = preempt_q;
`else
    assign expire      = 1'b0;
    assign bus.preempt = 1'b0;
`endif

    // Next-state logic: owner release takes priority over hold-limit preemption.
    always_comb begin
        state_d = state_q;
`ifdef ARB_HOLD_LIMIT_EN
        preempt_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (bus.request == 2'b11) begin
                    state_d = last_owner_q ? ARB_G0 : ARB_G1;
                end else if (bus.request[0]) begin
                    state_d = ARB_G0;
                end else if (bus.request[1]) begin
                    state_d = ARB_G1;
                end
            end
            ARB_G0: begin
                if (!bus.request[0]) begin
                    state_d = bus.request[1] ? ARB_G1 : ARB_IDLE;
                end else if (bus.request[1] && expire) begin
                    state_d = ARB_G1;
`ifdef ARB_HOLD_LIMIT_EN
                    preempt_d = 1'b1;
`endif
                end
            end
            ARB_G1: begin
                if (!bus.request[1]) begin
                    state_d = bus.request[0] ? ARB_G0 : ARB_IDLE;
                end else if (bus.request[0] && expire) begin
                    state_d = ARB_G0;
`ifdef ARB_HOLD_LIMIT_EN
                    preempt_d = 1'b1;
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Track the most recent owner on every entry into a grant state.
    always_comb begin
        last_owner_d = last_owner_q;
        if (state_d == ARB_G0) last_owner_d = 1'b0;
        if (state_d == ARB_G1) last_owner_d = 1'b1;
    end

    // State, owner and preempt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= ARB_RESET_OWNER;
`ifdef ARB_HOLD_LIMIT_EN
            preempt_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
`ifdef ARB_HOLD_LIMIT_EN
            preempt_q    <= preempt_d;
`endif
        end
    end

    assign bus.grant      = grant_of(state_q);
    assign bus.last_owner = last_owner_q;

endmodule

// File: tb/tb_arbiter_rr2.sv
// Self-checking bench for arbiter_rr2 with a tenure-based reference model.
module tb_arbiter_rr2;

    localparam int MH = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    arbiter_rr2_if bus ();

    arbiter_rr2 #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: current owner (-1 = none), contended cycles in this tenure.
    int   m_owner;
    int   m_hold;
    logic m_last;
    logic m_pre;

    function automatic logic [1:0] exp_grant();
        if (m_owner == 0) return 2'b01;
        if (m_owner == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_step(input logic [1:0] r, input logic rv);
        int nxt;
        int oth;
        if (rv) begin
            m_owner = -1; m_hold = 0; m_last = 1'b1; m_pre = 1'b0;
            return;
        end
        m_pre = 1'b0;
        nxt = m_owner;
        if (m_owner < 0) begin
            if (r == 2'b11)  nxt = (m_last == 1'b1) ? 0 : 1;
            else if (r[0])   nxt = 0;
            else if (r[1])   nxt = 1;
            else             nxt = -1;
        end else begin
            oth = 1 - m_owner;
            if (!r[m_owner]) begin
                nxt = r[oth] ? oth : -1;
            end else if (r[oth]) begin
                if (HOLD_EN && (m_hold + 1 >= MH)) begin
                    nxt = oth;
                    m_pre = 1'b1;
                end else begin
                    m_hold = m_hold + 1;
                end
            end else begin
                m_hold = 0;
            end
        end
        if (nxt != m_owner) begin
            m_hold = 0;
            if (nxt >= 0) m_last = (nxt == 1);
        end
        m_owner = nxt;
    endtask

    // Apply one cycle of inputs, advance the model on the edge, settle past it.
    task automatic tick(input logic [1:0] r, input logic rv);
        bus.request = r;
        rst = rv;
        @(posedge clk);
        model_step(r, rv);
        #1;
    endtask

    task automatic do_reset();
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.grant !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_grant: got %b want 00", bus.grant);
        end
        vectors++;
        if (bus.last_owner !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_last_owner: got %b want 1", bus.last_owner);
        end
        vectors++;
        if (bus.preempt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_preempt: got %b want 0", bus.preempt);
        end
    endtask

    task automatic test_reset_release();
        do_reset();
        tick(2'b00, 1'b0);
        tick(2'b01, 1'b0);
        vectors++;
        if (bus.grant !== 2'b01 || bus.last_owner !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got grant=%b last=%b want grant=01 last=0",
                     bus.grant, bus.last_owner);
        end
    endtask

    task automatic test_tie_handover();
        do_reset();
        tick(2'b11, 1'b0);
        vectors++;
        if (bus.grant !== 2'b01) begin
            miscompares++;
            $display("FAIL tie_first: got %b want 01", bus.grant);
        end
        tick(2'b11, 1'b0);
        tick(2'b10, 1'b0);
        vectors++;
        if (bus.grant !== 2'b10 || bus.preempt !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_handover: got grant=%b preempt=%b want grant=10 preempt=0",
                     bus.grant, bus.preempt);
        end
    endtask

    task automatic test_contention();
        logic [1:0] want_g;
        logic       want_p;
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            tick(2'b11, 1'b0);
            if (HOLD_EN) begin
                want_g = (((k - 1) / MH) % 2 == 1) ? 2'b10 : 2'b01;
                want_p = (k > 1) && ((k - 1) % MH == 0);
            end else begin
                want_g = 2'b01;
                want_p = 1'b0;
            end
            vectors++;
            if (bus.grant !== want_g || bus.preempt !== want_p) begin
                miscompares++;
                $display("FAIL contention cyc%0d: got grant=%b preempt=%b want grant=%b preempt=%b",
                         k, bus.grant, bus.preempt, want_g, want_p);
            end
        end
    endtask

    task automatic test_release_threshold();
        do_reset();
        tick(2'b11, 1'b0);
        for (int k = 0; k < MH - 1; k++) tick(2'b11, 1'b0);
        vectors++;
        if (bus.grant !== 2'b01) begin
            miscompares++;
            $display("FAIL thresh_hold: got %b want 01", bus.grant);
        end
        tick(2'b10, 1'b0);
        vectors++;
        if (bus.grant !== 2'b10 || bus.preempt !== 1'b0) begin
            miscompares++;
            $display("FAIL thresh_release: got grant=%b preempt=%b want grant=10 preempt=0",
                     bus.grant, bus.preempt);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        tick(2'b10, 1'b0);
        tick(2'b10, 1'b0);
        vectors++;
        if (bus.grant !== 2'b10) begin
            miscompares++;
            $display("FAIL midreset_setup: got %b want 10", bus.grant);
        end
        tick(2'b11, 1'b1);
        vectors++;
        if (bus.grant !== 2'b00 || bus.last_owner !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_edge: got grant=%b last=%b want grant=00 last=1",
                     bus.grant, bus.last_owner);
        end
        tick(2'b11, 1'b0);
        vectors++;
        if (bus.grant !== 2'b01) begin
            miscompares++;
            $display("FAIL midreset_after: got %b want 01", bus.grant);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        tick(2'b01, 1'b0);
        tick(2'b01, 1'b0);
        tick(2'b00, 1'b0);
        vectors++;
        if (bus.grant !== 2'b00) begin
            miscompares++;
            $display("FAIL glitch_drop: got %b want 00", bus.grant);
        end
        tick(2'b01, 1'b0);
        vectors++;
        if (bus.grant !== 2'b01) begin
            miscompares++;
            $display("FAIL glitch_reacquire: got %b want 01", bus.grant);
        end
    endtask

    task automatic test_random();
        logic [1:0] r;
        logic       rv;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) r = 2'b11;
            rv = ($urandom_range(0, 59) == 0);
            tick(r, rv);
            vectors++;
            if (bus.grant !== exp_grant() || bus.last_owner !== m_last ||
                bus.preempt !== m_pre || bus.grant === 2'b11) begin
                miscompares++;
                $display("FAIL random cyc%0d req=%b rst=%b: got grant=%b last=%b preempt=%b want grant=%b last=%b preempt=%b",
                         k, r, rv, bus.grant, bus.last_owner, bus.preempt,
                         exp_grant(), m_last, m_pre);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_owner     = -1;
        m_hold      = 0;
        m_last      = 1'b1;
        m_pre       = 1'b0;
        rst         = 1'b1;
        bus.request = 2'b00;
        test_reset();
        test_reset_release();
        test_tie_handover();
        test_contention();
        test_release_threshold();
        test_reset_mid_grant();
        test_glitch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
